// File: rtl/rgb_breath_pkg.sv
// Shared constants and helpers for the rainbow breathing LED array:
// colour indices, operating modes, channel masks and the per-LED phase reduction.
package rgb_breath_pkg;

    localparam logic [2:0] RED     = 3'd0;
    localparam logic [2:0] YELLOW  = 3'd1;
    localparam logic [2:0] GREEN   = 3'd2;
    localparam logic [2:0] CYAN    = 3'd3;
    localparam logic [2:0] BLUE    = 3'd4;
    localparam logic [2:0] MAGENTA = 3'd5;

    localparam logic [1:0] MODE_RAINBOW = 2'd0;
    localparam logic [1:0] MODE_WHITE   = 2'd1;
    localparam logic [1:0] MODE_STATIC  = 2'd2;
    localparam logic [1:0] MODE_OFF     = 2'd3;

    // Returns {R,G,B}; the unreachable codes 6 and 7 fall back to RED.
    function automatic logic [2:0] colour_mask(input logic [2:0] idx);
        logic [2:0] mask;
        case (idx)
            RED:     mask = 3'b100;
            YELLOW:  mask = 3'b110;
            GREEN:   mask = 3'b010;
            CYAN:    mask = 3'b011;
            BLUE:    mask = 3'b001;
            MAGENTA: mask = 3'b101;
            default: mask = 3'b100;
        endcase
        return mask;
    endfunction

    // (base + i*step) mod 6 with i <= 15 and step <= 7, so the product fits 8 bits.
    function automatic logic [2:0] idx_offset(input logic [2:0] base,
                                              input logic [4:0] i,
                                              input logic [2:0] step);
        logic [7:0] prod;
        logic [3:0] sum;
        prod = 8'(i) * 8'(step);
        sum  = 4'(base) + 4'(prod % 8'd6);
        return 3'(sum % 4'd6);
    endfunction

endpackage

// File: rtl/rgb_breath_array_pwm_cell.sv
// One RGB LED: period-aligned duty latches, comparators against the shared
// PWM counter and registered pin drivers.
module rgb_pwm_cell
    import rgb_breath_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [PWM_W-1:0]      pwm_cnt,
    input  logic [2:0][PWM_W-1:0] duty,
    output logic [2:0]            rgb_out
);

    logic [2:0][PWM_W-1:0] duty_q, duty_d;
    logic [2:0]            out_q, out_d;

    // Duties only change on the last count of a period, so a period never mixes two values.
    always_comb begin
        duty_d = duty_q;
        out_d  = '0;
        if (load) begin
            duty_d = duty;
        end
        for (int c = 0; c < 3; c++) begin
            out_d[c] = (pwm_cnt < duty_q[c]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= '0;
            out_q  <= '0;
        end else begin
            duty_q <= duty_d;
            out_q  <= out_d;
        end
    end

    assign rgb_out = out_q;

endmodule

// File: rtl/rgb_breath_array.sv
// Multi-LED rainbow breathing controller: prescaler, triangle envelope, colour
// sequencer and shared PWM counter driving NUM_LED phase-offset RGB cells.
module rgb_breath_array
    import rgb_breath_pkg::*;
#(
    parameter int NUM_LED    = 4,
    parameter int PWM_W      = 8,
    parameter int DIV_CNT    = 50000,
    parameter int PHASE_STEP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    output logic [NUM_LED-1:0] R_out,
    output logic [NUM_LED-1:0] G_out,
    output logic [NUM_LED-1:0] B_out,
    output logic               breath_done
);

    localparam int               PRE_W    = (DIV_CNT > 2) ? $clog2(DIV_CNT) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_CNT - 1);
    localparam logic [PWM_W-1:0] BRI_MAX  = '1;

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [PWM_W-1:0] bri_q, bri_d;
    logic             dir_down_q, dir_down_d;
    logic [2:0]       col_idx_q, col_idx_d;
    logic [PWM_W-1:0] static_cnt_q, static_cnt_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             breath_done_q, breath_done_d;

    logic       tick;
    logic       mode_chg;
    logic       pwm_wrap;
    logic [2:0] col_next;

    always_comb begin
        tick     = en && (presc_q == PRE_LAST);
        mode_chg = (mode != mode_q);
        pwm_wrap = (pwm_cnt_q == BRI_MAX);
        col_next = (col_idx_q >= MAGENTA) ? RED : col_idx_q + 3'd1;

        presc_d       = presc_q;
        bri_d         = bri_q;
        dir_down_d    = dir_down_q;
        col_idx_d     = col_idx_q;
        static_cnt_d  = static_cnt_q;
        breath_done_d = 1'b0;
        pwm_cnt_d     = pwm_cnt_q + PWM_W'(1);
        mode_d        = mode;

        if (en) begin
            presc_d = tick ? '0 : presc_q + PRE_W'(1);
        end

        // A mode change restarts the envelope and swallows a coincident tick.
        if (mode_chg) begin
            bri_d        = '0;
            dir_down_d   = 1'b0;
            static_cnt_d = '0;
        end else if (tick) begin
            if (mode_q == MODE_STATIC) begin
                bri_d        = BRI_MAX;
                static_cnt_d = static_cnt_q + PWM_W'(1);
                if (static_cnt_q == BRI_MAX) begin
                    col_idx_d = col_next;
                end
            end else if (!dir_down_q) begin
                if (bri_q == BRI_MAX) begin
                    dir_down_d = 1'b1;
                    bri_d      = bri_q - PWM_W'(1);
                end else begin
                    bri_d = bri_q + PWM_W'(1);
                end
            end else begin
                if (bri_q <= PWM_W'(1)) begin
                    bri_d         = '0;
                    dir_down_d    = 1'b0;
                    breath_done_d = 1'b1;
                    if (mode_q == MODE_RAINBOW) begin
                        col_idx_d = col_next;
                    end
                end else begin
                    bri_d = bri_q - PWM_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q       <= '0;
            bri_q         <= '0;
            dir_down_q    <= 1'b0;
            col_idx_q     <= RED;
            static_cnt_q  <= '0;
            pwm_cnt_q     <= '0;
            mode_q        <= MODE_RAINBOW;
            breath_done_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            bri_q         <= bri_d;
            dir_down_q    <= dir_down_d;
            col_idx_q     <= col_idx_d;
            static_cnt_q  <= static_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            mode_q        <= mode_d;
            breath_done_q <= breath_done_d;
        end
    end

    assign breath_done = breath_done_q;

    for (genvar i = 0; i < NUM_LED; i++) begin : g_led
        logic [2:0]            idx;
        logic [2:0]            mask;
        logic [2:0][PWM_W-1:0] duty_tgt;
        logic [2:0]            rgb;

        // Channel order inside the cell follows the mask: [2]=R, [1]=G, [0]=B.
        always_comb begin
            idx      = idx_offset(col_idx_q, 5'(i), 3'(PHASE_STEP));
            mask     = colour_mask(idx);
            duty_tgt = '0;
            for (int c = 0; c < 3; c++) begin
                case (mode_q)
                    MODE_RAINBOW: if (mask[c]) duty_tgt[c] = bri_q;
                    MODE_WHITE:   duty_tgt[c] = bri_q;
                    MODE_STATIC:  if (mask[c]) duty_tgt[c] = BRI_MAX;
                    default:      duty_tgt[c] = '0;
                endcase
            end
        end

        rgb_pwm_cell #(
            .PWM_W(PWM_W)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .load    (pwm_wrap),
            .pwm_cnt (pwm_cnt_q),
            .duty    (duty_tgt),
            .rgb_out (rgb)
        );

        assign R_out[i] = rgb[2];
        assign G_out[i] = rgb[1];
        assign B_out[i] = rgb[0];
    end

endmodule

// File: doc/rgb_breath_array.md
Name: rgb_breath_array

Overview:
Parametrised multi-LED rainbow breathing controller. It merges the clock divider, the pattern decoder and the RGB PWM stages into one block. One shared breathing envelope and colour sequencer drive NUM_LED RGB LEDs, each with a per-LED colour phase offset. A mode input selects rainbow breathing, white breathing, static colour or off. The block sits at top level, directly driving the board RGB pins.

Parameters:
NUM_LED, 4, number of RGB LEDs driven (1..16)
PWM_W, 8, PWM/duty resolution in bits; PWM period = 2^PWM_W clk cycles
DIV_CNT, 50000, clk cycles per envelope tick (>=2)
PHASE_STEP, 1, colour-index offset between adjacent LEDs (0..5)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
en  input  1  1 = envelope/colour advance; 0 = freeze pattern (PWM keeps running)
mode  input  2  0 rainbow breathe, 1 white breathe, 2 static rainbow, 3 off
R_out  output  NUM_LED  red PWM per LED, active high
G_out  output  NUM_LED  green PWM per LED, active high
B_out  output  NUM_LED  blue PWM per LED, active high
breath_done  output  1  one-clk pulse when the envelope returns to 0 (end of a breath)

Behaviour:
- Reset (async, rst=1): all counters 0, bri=0, dir=up, col_idx=0 (RED), latched duties 0, all R/G/B_out=0, breath_done=0.
- Prescaler: counts 0..DIV_CNT-1 while en=1, then wraps; tick=1 for the clk where prescaler==DIV_CNT-1. With en=0 the prescaler holds and tick=0.
- Envelope, updated on tick:
  - Triangle wave: bri increments by 1 while dir=up, decrements by 1 while dir=down.
  - At bri==2^PWM_W-1 with dir=up: dir<=down, bri decrements next tick (no repeated peak).
  - At bri==1 with dir=down: bri<=0, dir<=up, breath_done pulses the same clk.
  - Full breath = 2*(2^PWM_W-1) ticks.
- Colour sequencer:
  - 6 states RED(0), YELLOW(1), GREEN(2), CYAN(3), BLUE(4), MAGENTA(5).
  - col_idx advances mod 6 on breath_done in mode 0.
  - In mode 2 it advances every 2^PWM_W ticks and bri is held at max.
- Per-LED colour: idx_i = (col_idx + i*PHASE_STEP) mod 6.
  - Channel masks: RED=R; YELLOW=R+G; GREEN=G; CYAN=G+B; BLUE=B; MAGENTA=R+B.
- Duty per channel:
  - mode 0: bri if the channel is in the mask, else 0.
  - mode 1: bri on all channels.
  - mode 2: 2^PWM_W-1 on masked channels.
  - mode 3: 0.
- PWM:
  - Shared free-running pwm_cnt (PWM_W bits) wraps at 2^PWM_W-1.
  - Target duties are latched into per-channel registers only on the clk where pwm_cnt==2^PWM_W-1, so there are no mid-period glitches.
  - out = (pwm_cnt < duty_latched), registered; one clk latency from compare to pin.
  - duty 0 gives a constant 0; max duty gives (2^PWM_W-1)/2^PWM_W high.
- Mode change: detected by comparing against a registered mode. On change, bri<=0 and dir<=up; col_idx and prescaler are kept. The new duties appear from the next PWM period boundary.
- en=0 mid-breath: bri, dir, col_idx and the prescaler freeze; PWM continues at the frozen duties. en=1 resumes from the held prescaler value.
- Simultaneous tick and mode change: the mode change wins (envelope reset); the tick is discarded.
- Reset mid-period: outputs drop to 0 immediately (async); the first full PWM period starts after rst is released.
- Width rules:
  - bri is PWM_W bits, with no wrap beyond the endpoints.
  - col_idx is 3 bits; states 6 and 7 are unreachable, and the decoder maps them to RED.
  - Phase math uses a 3-bit mod-6 reduction, so i*PHASE_STEP must be reduced without overflow for NUM_LED<=16.

Decomposition:
- Package rgb_breath_pkg holds:
  - the colour index constants RED..MAGENTA;
  - the MODE_RAINBOW/WHITE/STATIC/OFF constants;
  - a function colour_mask(idx) returning the 3-bit {R,G,B} mask;
  - a function idx_offset(base, i, step) doing the mod-6 reduction.
- One sub-module, rgb_pwm_cell. It is instantiated NUM_LED times and contains:
  - three duty latch registers;
  - three comparators against the shared pwm_cnt;
  - the registered outputs.
- The prescaler, envelope, sequencer and pwm_cnt stay in the top of this block.

Test Plan:
1. Reset: NUM_LED=3, PWM_W=4, DIV_CNT=2, hold rst mid-run -> all outputs 0 within the same clk. After release, bri=0 and col_idx=0.
2. Envelope, mode 0, en=1 -> bri reaches 15 after 15 ticks (30 clk) and returns to 0 after 30 ticks. breath_done pulses exactly once per 60 clk, after which col_idx=1.
3. Phase offset, PHASE_STEP=2, col_idx=0 -> LED0 R only, LED1 G only (GREEN), LED2 B only (BLUE). The R duty cycle on LED0 measured over 16 clk equals the latched bri.
4. Mode 1 at bri=8 -> R, G and B on every LED are high for 8 of 16 clk. Mode 3 -> all low for 64 clk.
5. Glitch-free update: change the target duty mid-period at pwm_cnt=5 -> the output waveform is unchanged until pwm_cnt wraps, and the new duty applies in the next period.
6. en=0 at bri=7 for 100 clk -> bri stays 7, the PWM duty stays 7/16, and no breath_done. After en=1 the next tick gives bri=8. A mode change coinciding with a tick gives bri=0.
